// File: rtl/rob_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_unit_pkg
//  Description : Shared constants, entry layout and tag helper for the
//                reorder buffer (rob_unit and rob_query_port).
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_unit_pkg;

  localparam int ROB_DEPTH = 16;   // number of live entries, tags 1..ROB_DEPTH
  localparam int ROB_TAG_W = 5;    // tag width, 2**ROB_TAG_W > ROB_DEPTH
  localparam int NO_TAG    = 0;    // tag 0 means "no dependency"
  localparam int XLEN      = 32;   // value / PC width
  localparam int RD_W      = 5;    // architectural register index width

  // Per-entry fields captured at issue time
  typedef struct packed {
    logic            rd_hv;
    logic [RD_W-1:0] rd;
    logic            is_br;
    logic [XLEN-1:0] pred_pc;
  } rob_meta_t;

  // Tag increment with wrap DEPTH -> 1; tag 0 is never produced
  function automatic int tag_inc(input int tag, input int depth);
    return (tag >= depth) ? 1 : tag + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_unit_query_port.sv
`default_nettype none
// ============================================================================
//  Module      : rob_query_port
//  Description : Combinational operand-readiness lookup into the reorder
//                buffer. Build option ROB_CDB_BYPASS_EN also matches the
//                current-cycle CDB broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_query_port
  import rob_unit_pkg::*;
#(
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic [TAG_W-1:0]                   i_id,
  input  logic [(2**TAG_W)-1:0]              i_valid,
  input  logic [(2**TAG_W)-1:0]              i_ready,
  input  logic [(2**TAG_W)-1:0][XLEN-1:0]    i_value,
`ifdef ROB_CDB_BYPASS_EN
  input  logic                               i_cdb_valid,
  input  logic [TAG_W-1:0]                   i_cdb_tag,
  input  logic [XLEN-1:0]                    i_cdb_value,
`endif
  output logic                               o_ready,
  output logic [XLEN-1:0]                    o_value
);

  // Stored result lookup, optionally overridden by a same-cycle broadcast
  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if ((i_id != TAG_W'(NO_TAG)) && i_valid[i_id] && i_ready[i_id]) begin
      o_ready = 1'b1;
      o_value = i_value[i_id];
    end
`ifdef ROB_CDB_BYPASS_EN
    if ((i_id != TAG_W'(NO_TAG)) && i_cdb_valid && (i_cdb_tag == i_id) && i_valid[i_id]) begin
      o_ready = 1'b1;
      o_value = i_cdb_value;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/rob_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_unit
//  Description : Circular reorder buffer. Allocates tags 1..DEPTH on issue,
//                collects CDB results, answers two operand queries and
//                commits in order, flushing on branch misprediction.
//                Build option: ROB_CDB_BYPASS_EN (same-cycle CDB bypass for
//                queries and head commit).
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_unit
  import rob_unit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic             issue_rd_hv,
  input  logic [RD_W-1:0]  issue_rd,
  input  logic             issue_is_br,
  input  logic             issue_pred_taken,
  input  logic [XLEN-1:0]  issue_pred_pc,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic [XLEN-1:0]  cdb_next_pc,
  input  logic [TAG_W-1:0] rs1_id,
  input  logic [TAG_W-1:0] rs2_id,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [XLEN-1:0]  rs1_value,
  output logic [XLEN-1:0]  rs2_value,
  output logic             commit_valid,
  output logic [RD_W-1:0]  commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc
);

  localparam int N = 2**TAG_W;

  logic [TAG_W-1:0]          r_head, r_tail, r_count;
  logic                      r_flush;
  logic [XLEN-1:0]           r_flush_pc;
  logic [N-1:0]              r_valid, r_ready;
  logic [N-1:0][XLEN-1:0]    r_value, r_next_pc;
  rob_meta_t                 r_meta [N];

  logic                      w_full, w_issue, w_cdb_we, w_head_byp;
  logic                      w_head_ready, w_mispredict;
  logic [XLEN-1:0]           w_head_value, w_head_npc;
  logic [TAG_W-1:0]          w_head_inc, w_tail_inc;
  rob_meta_t                 w_head_meta;
  logic                      w_unused_pred;

  // Predicted direction is informational only; mispredict uses the PC compare
  assign w_unused_pred = issue_pred_taken;

  assign w_full     = (r_count == TAG_W'(DEPTH)) | r_flush;
  assign w_issue    = issue_valid & ~w_full & rdy;
  assign w_cdb_we   = rdy & ~r_flush & cdb_valid & (cdb_tag != TAG_W'(NO_TAG)) & r_valid[cdb_tag];
  assign w_head_inc = TAG_W'(tag_inc(int'(r_head), DEPTH));
  assign w_tail_inc = TAG_W'(tag_inc(int'(r_tail), DEPTH));
  assign w_head_meta = r_meta[r_head];

`ifdef ROB_CDB_BYPASS_EN
  assign w_head_byp = cdb_valid & (cdb_tag == r_head) & r_valid[r_head];
`else
  assign w_head_byp = 1'b0;
`endif

  assign w_head_ready = r_ready[r_head] | w_head_byp;
  assign w_head_value = w_head_byp ? cdb_value   : r_value[r_head];
  assign w_head_npc   = w_head_byp ? cdb_next_pc : r_next_pc[r_head];

  assign commit_valid = rdy & ~r_flush & (r_count != '0) & w_head_ready;
  assign w_mispredict = commit_valid & w_head_meta.is_br & (w_head_npc != w_head_meta.pred_pc);

  assign alloc_tag    = r_tail;
  assign full         = w_full;
  assign commit_rd    = w_head_meta.rd_hv ? w_head_meta.rd : '0;
  assign commit_value = w_head_value;
  assign commit_tag   = r_head;
  assign flush        = r_flush;
  assign flush_pc     = r_flush_pc;

  // Pointers, occupancy, entry status bits and the flush pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= TAG_W'(1);
      r_tail     <= TAG_W'(1);
      r_count    <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
      r_valid    <= '0;
      r_ready    <= '0;
    end else if (rdy) begin
      r_flush <= w_mispredict;
      if (w_mispredict) begin
        r_flush_pc <= w_head_npc;
        r_head     <= TAG_W'(1);
        r_tail     <= TAG_W'(1);
        r_count    <= '0;
        r_valid    <= '0;
      end else begin
        if (w_issue) begin
          r_tail           <= w_tail_inc;
          r_valid[r_tail]  <= 1'b1;
          r_ready[r_tail]  <= 1'b0;
        end
        if (w_cdb_we) begin
          r_ready[cdb_tag] <= 1'b1;
        end
        if (commit_valid) begin
          r_head           <= w_head_inc;
          r_valid[r_head]  <= 1'b0;
        end
        case ({w_issue, commit_valid})
          2'b10:   r_count <= r_count + TAG_W'(1);
          2'b01:   r_count <= r_count - TAG_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload: issue fields and CDB results (validity lives above)
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (w_issue) begin
        r_meta[r_tail] <= '{rd_hv: issue_rd_hv, rd: issue_rd,
                            is_br: issue_is_br, pred_pc: issue_pred_pc};
      end
      if (w_cdb_we) begin
        r_value[cdb_tag]   <= cdb_value;
        r_next_pc[cdb_tag] <= cdb_next_pc;
      end
    end
  end

  rob_query_port #(.TAG_W(TAG_W)) u_q_rs1 (
    .i_id        (rs1_id),
    .i_valid     (r_valid),
    .i_ready     (r_ready),
    .i_value     (r_value),
`ifdef ROB_CDB_BYPASS_EN
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_value (cdb_value),
`endif
    .o_ready     (rs1_ready),
    .o_value     (rs1_value)
  );

  rob_query_port #(.TAG_W(TAG_W)) u_q_rs2 (
    .i_id        (rs2_id),
    .i_valid     (r_valid),
    .i_ready     (r_ready),
    .i_value     (r_value),
`ifdef ROB_CDB_BYPASS_EN
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_value (cdb_value),
`endif
    .o_ready     (rs2_ready),
    .o_value     (rs2_value)
  );

endmodule
`default_nettype wire

// File: tb/tb_rob_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_unit
//  Description : Directed self-checking bench for rob_unit; expectations
//                adapt to the ROB_CDB_BYPASS_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_unit;

  logic        clk, rst, rdy;
  logic        issue_valid, issue_rd_hv, issue_is_br, issue_pred_taken;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc;
  logic [4:0]  alloc_tag;
  logic        full;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_next_pc;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_value, rs2_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [4:0]  commit_tag;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_errors = 0;

  rob_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd_hv(issue_rd_hv), .issue_rd(issue_rd),
    .issue_is_br(issue_is_br), .issue_pred_taken(issue_pred_taken),
    .issue_pred_pc(issue_pred_pc), .alloc_tag(alloc_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_next_pc(cdb_next_pc), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic hv, input logic [4:0] rd, input logic br, input logic [31:0] ppc);
    issue_valid   = 1'b1;
    issue_rd_hv   = hv;
    issue_rd      = rd;
    issue_is_br   = br;
    issue_pred_pc = ppc;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input logic [31:0] npc);
    cdb_valid   = 1'b1;
    cdb_tag     = tag;
    cdb_value   = val;
    cdb_next_pc = npc;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    issue_valid = 0; issue_rd_hv = 0; issue_rd = 0; issue_is_br = 0;
    issue_pred_taken = 0; issue_pred_pc = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_next_pc = 0;
    rs1_id = 0; rs2_id = 0;
    step(); step();
    chk("rst_alloc", 32'(alloc_tag), 1);
    chk("rst_head", 32'(commit_tag), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_fpc", flush_pc, 0);
    rst = 1'b1;

    // Issue three instructions rd=5,6,7
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'(5 + i), 1'b0, 32'h0);
      #1 chk("iss_alloc", 32'(alloc_tag), 32'(i + 1));
      step();
    end
    issue_valid = 0;
    #1;
    chk("iss3_alloc", 32'(alloc_tag), 4);
    chk("iss3_full", 32'(full), 0);
    chk("iss3_cv", 32'(commit_valid), 0);

    // Out-of-order completion: tag2 first, then tag1
    cdb(5'd2, 32'hAA, 32'h0);
    #1 chk("cdb2_cv", 32'(commit_valid), 0);
    step();
    cdb(5'd1, 32'h11, 32'h0);
    #1;
`ifndef ROB_CDB_BYPASS_EN
    chk("cdb1_cv_nobyp", 32'(commit_valid), 0);
    step();
    cdb_valid = 0;
    #1;
`endif
    chk("c1_cv", 32'(commit_valid), 1);
    chk("c1_rd", 32'(commit_rd), 5);
    chk("c1_val", commit_value, 32'h11);
    chk("c1_tag", 32'(commit_tag), 1);
    step();
    cdb_valid = 0;
    #1;
    chk("c2_cv", 32'(commit_valid), 1);
    chk("c2_rd", 32'(commit_rd), 6);
    chk("c2_val", commit_value, 32'hAA);
    chk("c2_tag", 32'(commit_tag), 2);
    step();
    chk("c3_wait", 32'(commit_valid), 0);
    chk("c3_tag", 32'(commit_tag), 3);

    // Operand query on a pending entry, then with a same-cycle broadcast
    rs1_id = 5'd3; rs2_id = 5'd0;
    #1;
    chk("q_rdy", 32'(rs1_ready), 0);
    chk("q_val", rs1_value, 0);
    cdb(5'd3, 32'h55, 32'h0);
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("qb_rdy", 32'(rs1_ready), 1);
    chk("qb_val", rs1_value, 32'h55);
    chk("qb_cv", 32'(commit_valid), 1);
    chk("qb_cval", commit_value, 32'h55);
    step();
    cdb_valid = 0;
    #1;
`else
    chk("qb_rdy", 32'(rs1_ready), 0);
    chk("qb_val", rs1_value, 0);
    chk("qb_cv", 32'(commit_valid), 0);
    step();
    cdb_valid = 0;
    #1;
    chk("qa_rdy", 32'(rs1_ready), 1);
    chk("qa_val", rs1_value, 32'h55);
    chk("qa_cv", 32'(commit_valid), 1);
    chk("qa_rd", 32'(commit_rd), 7);
    step();
`endif
    chk("q0_rdy", 32'(rs2_ready), 0);
    chk("q0_val", rs2_value, 0);
    chk("empty_cv", 32'(commit_valid), 0);
    chk("empty_alloc", 32'(alloc_tag), 4);

    // Fill all 16 entries: tags 4..16 then wrap to 1..3
    for (int i = 0; i < 16; i++) begin
      issue(i != 0, (i == 0) ? 5'd9 : 5'(i + 1), 1'b0, 32'h0);
      #1 chk("fill_alloc", 32'(alloc_tag), 32'(((3 + i) % 16) + 1));
      step();
    end
    issue_valid = 0;
    #1;
    chk("fill_full", 32'(full), 1);
    chk("fill_alloc_end", 32'(alloc_tag), 4);
    issue(1'b1, 5'd20, 1'b0, 32'h0);
    step();
    chk("ovf_alloc", 32'(alloc_tag), 4);
    chk("ovf_full", 32'(full), 1);

    // Head completes; issue held while full with commit must be rejected
    cdb(5'd4, 32'h44, 32'h0);
    #1;
`ifndef ROB_CDB_BYPASS_EN
    step();
    cdb_valid = 0;
    #1;
`endif
    chk("w_cv", 32'(commit_valid), 1);
    chk("w_rd0", 32'(commit_rd), 0);
    chk("w_val", commit_value, 32'h44);
    chk("w_full_nola", 32'(full), 1);
    step();
    cdb_valid = 0;
    #1;
    chk("w_alloc", 32'(alloc_tag), 4);
    chk("w_full0", 32'(full), 0);
    chk("w_head", 32'(commit_tag), 5);
    step();
    issue_valid = 0;
    chk("w_alloc2", 32'(alloc_tag), 5);
    chk("w_full1", 32'(full), 1);

    // Make tag6 ready ahead of head, then commit tag5
    cdb(5'd6, 32'h66, 32'h0);
    step();
    cdb(5'd5, 32'h77, 32'h0);
    #1;
`ifndef ROB_CDB_BYPASS_EN
    step();
    cdb_valid = 0;
    #1;
`endif
    chk("c5_cv", 32'(commit_valid), 1);
    chk("c5_rd", 32'(commit_rd), 2);
    chk("c5_val", commit_value, 32'h77);
    step();
    cdb_valid = 0;

    // rdy low with a ready head: nothing moves, issue ignored
    rdy = 1'b0;
    issue(1'b1, 5'd1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rdy_cv", 32'(commit_valid), 0);
      chk("rdy_head", 32'(commit_tag), 6);
      chk("rdy_alloc", 32'(alloc_tag), 5);
      step();
    end
    issue_valid = 0;
    rdy = 1'b1;
    #1;
    chk("rdy_cv1", 32'(commit_valid), 1);
    chk("rdy_rd", 32'(commit_rd), 3);
    chk("rdy_val", commit_value, 32'h66);

    // Asynchronous reset away from the clock edge
    rst = 1'b0;
    #1;
    chk("arst_alloc", 32'(alloc_tag), 1);
    chk("arst_head", 32'(commit_tag), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_cv", 32'(commit_valid), 0);
    chk("arst_flush", 32'(flush), 0);
    step();
    rst = 1'b1;

    // Mispredicted branch: tag1 pred 0x104, resolved 0x200
    issue(1'b1, 5'd10, 1'b1, 32'h104);
    step();
    issue(1'b1, 5'd11, 1'b0, 32'h0);
    step();
    issue_valid = 0;
    cdb(5'd1, 32'h108, 32'h200);
    #1;
`ifndef ROB_CDB_BYPASS_EN
    step();
    cdb_valid = 0;
    #1;
`endif
    chk("br_cv", 32'(commit_valid), 1);
    chk("br_rd", 32'(commit_rd), 10);
    chk("br_val", commit_value, 32'h108);
    chk("br_tag", 32'(commit_tag), 1);
    chk("br_flush0", 32'(flush), 0);
    issue(1'b1, 5'd12, 1'b0, 32'h0);
    step();
    cdb_valid = 0;
    chk("fl_flush", 32'(flush), 1);
    chk("fl_pc", flush_pc, 32'h200);
    chk("fl_alloc", 32'(alloc_tag), 1);
    chk("fl_full", 32'(full), 1);
    chk("fl_cv", 32'(commit_valid), 0);
    step();
    chk("pf_flush", 32'(flush), 0);
    chk("pf_alloc", 32'(alloc_tag), 1);
    chk("pf_full", 32'(full), 0);
    chk("pf_head", 32'(commit_tag), 1);
    step();
    issue_valid = 0;
    chk("pf_alloc2", 32'(alloc_tag), 2);
    chk("pf_cv", 32'(commit_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
